// File: rtl/core_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | core_pkg - shared types and constants for the multi-cycle MIPS core  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  localparam logic [5:0]  OPC_INVALID      = 6'b111111;
  localparam int          OPC_HI           = 31;
  localparam int          OPC_LO           = 26;
  localparam int          FUNCT_HI         = 5;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_target_calc - branch/jump redirect target from the current pc     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_target_calc #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [15:0]       branchOffset,
  input  logic [25:0]       jumpIndex,
  input  logic              jumpTaken,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] jump_tgt;

  // Word offset, sign-extended; the add wraps naturally at 2^ADDR_W.
  assign branch_tgt = pc + {{(ADDR_W-18){branchOffset[15]}}, branchOffset, 2'b00};
  assign jump_tgt   = {pc[ADDR_W-1:ADDR_W-4], jumpIndex, 2'b00};
  assign target     = jumpTaken ? jump_tgt : branch_tgt;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_unit - instruction fetch stage with redirect/squash handling   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fetch_unit
  import core_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemReady,
  input  logic [31:0]       imemData,
  output logic              irValid,
  input  logic              irAccept,
  output logic [31:0]       instr,
  output logic [5:0]        opCode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pcPlus4,
  input  logic              branchTaken,
  input  logic [15:0]       branchOffset,
  input  logic              jumpTaken,
  input  logic [25:0]       jumpIndex
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [31:0]       instr_nxt;
  logic              squash, squash_nxt;
  logic [ADDR_W-1:0] redir_tgt, redir_tgt_nxt;
  logic [ADDR_W-1:0] target;
  logic              redirect;

  assign redirect = branchTaken | jumpTaken;

  pc_target_calc #(
    .ADDR_W(ADDR_W)
  ) u_pc_target_calc (
    .pc          (pc),
    .branchOffset(branchOffset),
    .jumpIndex   (jumpIndex),
    .jumpTaken   (jumpTaken),
    .target      (target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      instr     <= '0;
      squash    <= 1'b0;
      redir_tgt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      instr     <= instr_nxt;
      squash    <= squash_nxt;
      redir_tgt <= redir_tgt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    instr_nxt     = instr;
    squash_nxt    = squash;
    redir_tgt_nxt = redir_tgt;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (!imemReady) begin
          // Redirect arrived while the word is outstanding: remember it, keep address stable.
          if (redirect) begin
            squash_nxt    = 1'b1;
            redir_tgt_nxt = target;
          end
        end else if (redirect || squash) begin
          pc_nxt     = redirect ? target : redir_tgt;
          squash_nxt = 1'b0;
        end else begin
          instr_nxt = imemData;
          pc_nxt    = pc + ADDR_W'(4);
          state_nxt = ST_VALID;
        end
      end
      ST_VALID: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = ST_FETCH;
        end else if (irAccept) begin
          state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign imemReq  = (state == ST_FETCH);
  assign imemAddr = pc;
  assign irValid  = (state == ST_VALID);
  assign opCode   = irValid ? instr[OPC_HI:OPC_LO] : OPC_INVALID;
  assign funct    = instr[FUNCT_HI:0];
  assign pcPlus4  = pc;

endmodule
`default_nettype wire
